// File: rtl/dmawr_line_writer.sv
`timescale 1ns/1ps
// dmawr_line_writer
// Write-side stage of the DMA write path. Buffers one AXI-stream pixel line at a
// time in a first-word-fall-through FIFO and drains it as length-bounded memory
// write bursts to a pitch-strided line address. Tracks line and frame position.
//
// Ports:
//   sysclk, sysrst            clock, synchronous active-high reset
//   cfg_*                     enable, frame base address, line pitch, lines per frame
//   s_axis_*                  incoming pixel line (tvalid/tready/tdata/tstrb/tlast)
//   mem_wr_req/ack/addr/len   burst request handshake
//   mem_wr_valid/ready/data/strb  burst data beats
//   m_axis_status_*           optional one-beat per-line status stream
//   busy, frame_done, line_index  progress indicators
//
// Build option: define DMAWR_STATUS_STREAM_EN to emit a status beat at the end of
// each line and hold off the next line until it is accepted. Otherwise the status
// outputs are tied to zero.
module dmawr_line_writer #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 64,
    parameter int unsigned MAX_BURST  = 16
) (
    input  logic                    sysclk,
    input  logic                    sysrst,
    input  logic                    cfg_enable,
    input  logic [ADDR_WIDTH-1:0]   cfg_start_addr,
    input  logic [15:0]             cfg_line_pitch,
    input  logic [11:0]             cfg_lines_per_frame,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_axis_tstrb,
    input  logic                    s_axis_tlast,
    output logic                    mem_wr_req,
    input  logic                    mem_wr_ack,
    output logic [ADDR_WIDTH-1:0]   mem_wr_addr,
    output logic [4:0]              mem_wr_len,
    output logic                    mem_wr_valid,
    input  logic                    mem_wr_ready,
    output logic [DATA_WIDTH-1:0]   mem_wr_data,
    output logic [DATA_WIDTH/8-1:0] mem_wr_strb,
    output logic                    m_axis_status_tvalid,
    input  logic                    m_axis_status_tready,
    output logic [63:0]             m_axis_status_tdata,
    output logic [7:0]              m_axis_status_tstrb,
    output logic                    m_axis_status_tlast,
    output logic                    busy,
    output logic                    frame_done,
    output logic [11:0]             line_index
);

    localparam int unsigned StrbW  = DATA_WIDTH / 8;
    localparam int unsigned EntryW = DATA_WIDTH + StrbW + 1;
    localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW   = PtrW + 1;

    typedef enum logic [2:0] {StIdle, StCollect, StReq, StData, StLineEnd} state_e;

    state_e state_q, state_d;

    logic [EntryW-1:0]     fifo_mem [FIFO_DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]       fifo_count_q;
    logic [EntryW-1:0]     head;
    logic                  fifo_full, push, pop;
    logic                  line_closed_q;
    logic [ADDR_WIDTH-1:0] line_addr_q, burst_addr_q;
    logic [11:0]           line_index_q, line_beats_q, last_index;
    logic [4:0]            len_q, beats_left_q, burst_len;
    logic                  frame_done_q, line_end_go, leave_line_end, enter_req;

    assign head          = fifo_mem[rd_ptr_q];
    assign fifo_full     = (fifo_count_q == CntW'(FIFO_DEPTH));
    assign s_axis_tready = (state_q != StIdle) && !fifo_full && !line_closed_q;
    assign push          = s_axis_tvalid && s_axis_tready;
    assign mem_wr_valid  = (state_q == StData);
    assign pop           = mem_wr_valid && mem_wr_ready;
    assign mem_wr_data   = mem_wr_valid ? head[DATA_WIDTH-1:0] : '0;
    assign mem_wr_strb   = mem_wr_valid ? head[DATA_WIDTH +: StrbW] : '0;
    assign mem_wr_req    = (state_q == StReq);
    assign mem_wr_addr   = burst_addr_q;
    assign mem_wr_len    = len_q;
    assign busy          = (state_q != StIdle);
    assign frame_done    = frame_done_q;
    assign line_index    = line_index_q;

    // A zero lines-per-frame setting behaves as a one-line frame.
    assign last_index = (cfg_lines_per_frame == 12'd0) ? 12'd0 : cfg_lines_per_frame - 12'd1;
    assign burst_len  = (fifo_count_q >= CntW'(MAX_BURST)) ? 5'(MAX_BURST) : 5'(fifo_count_q);

`ifdef DMAWR_STATUS_STREAM_EN
    assign m_axis_status_tvalid = (state_q == StLineEnd);
    assign m_axis_status_tdata  = m_axis_status_tvalid ?
                                  {36'd0, line_beats_q, 4'd0, line_index_q} : 64'd0;
    assign m_axis_status_tstrb  = m_axis_status_tvalid ? 8'hFF : 8'h00;
    assign m_axis_status_tlast  = m_axis_status_tvalid;
    assign line_end_go          = m_axis_status_tready;
`else
    logic unused_status;
    assign unused_status        = ^{m_axis_status_tready, line_beats_q};
    assign m_axis_status_tvalid = 1'b0;
    assign m_axis_status_tdata  = 64'd0;
    assign m_axis_status_tstrb  = 8'h00;
    assign m_axis_status_tlast  = 1'b0;
    assign line_end_go          = 1'b1;
`endif

    assign leave_line_end = (state_q == StLineEnd) && line_end_go;
    assign enter_req      = (state_q == StCollect) && (state_d == StReq);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (cfg_enable) state_d = StCollect;
            StCollect: begin
                if ((fifo_count_q >= CntW'(MAX_BURST)) ||
                    (line_closed_q && (fifo_count_q != '0))) begin
                    state_d = StReq;
                end
            end
            StReq:     if (mem_wr_ack) state_d = StData;
            StData: begin
                // Only one line is resident, so a tlast beat always ends its burst.
                if (pop && (beats_left_q == 5'd1)) begin
                    state_d = head[EntryW-1] ? StLineEnd : StCollect;
                end
            end
            StLineEnd: if (line_end_go) state_d = cfg_enable ? StCollect : StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Storage carries no reset; the pointers define what is valid.
    always_ff @(posedge sysclk) begin
        if (push) fifo_mem[wr_ptr_q] <= {s_axis_tlast, s_axis_tstrb, s_axis_tdata};
    end

    always_ff @(posedge sysclk) begin
        if (sysrst) begin
            state_q       <= StIdle;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fifo_count_q  <= '0;
            line_closed_q <= 1'b0;
            line_addr_q   <= '0;
            burst_addr_q  <= '0;
            line_index_q  <= '0;
            line_beats_q  <= '0;
            len_q         <= '0;
            beats_left_q  <= '0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_done_q <= 1'b0;
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            if (push && !pop) begin
                fifo_count_q <= fifo_count_q + CntW'(1);
            end else if (!push && pop) begin
                fifo_count_q <= fifo_count_q - CntW'(1);
            end
            if ((state_q == StData) && (state_d == StLineEnd)) begin
                line_closed_q <= 1'b0;
            end else if (push && s_axis_tlast) begin
                line_closed_q <= 1'b1;
            end
            if (enter_req) begin
                len_q        <= burst_len;
                beats_left_q <= burst_len;
            end
            if (pop) begin
                beats_left_q <= beats_left_q - 5'd1;
                burst_addr_q <= burst_addr_q + ADDR_WIDTH'(8);
                line_beats_q <= line_beats_q + 12'd1;
            end
            if (state_q == StIdle) begin
                line_addr_q  <= cfg_start_addr;
                burst_addr_q <= cfg_start_addr;
                line_index_q <= '0;
                line_beats_q <= '0;
            end
            if (leave_line_end) begin
                line_beats_q <= '0;
                if (line_index_q == last_index) begin
                    frame_done_q <= 1'b1;
                    line_index_q <= '0;
                    line_addr_q  <= cfg_start_addr;
                    burst_addr_q <= cfg_start_addr;
                end else begin
                    line_index_q <= line_index_q + 12'd1;
                    line_addr_q  <= line_addr_q + ADDR_WIDTH'(cfg_line_pitch);
                    burst_addr_q <= line_addr_q + ADDR_WIDTH'(cfg_line_pitch);
                end
            end
        end
    end

endmodule

// File: tb/tb_dmawr_line_writer.sv
`timescale 1ns/1ps
module tb_dmawr_line_writer;

    localparam int FifoDepth = 64;

    logic        sysclk = 1'b0;
    logic        sysrst = 1'b1;
    logic        cfg_enable = 1'b0;
    logic [31:0] cfg_start_addr = '0;
    logic [15:0] cfg_line_pitch = '0;
    logic [11:0] cfg_lines_per_frame = '0;
    logic        s_axis_tvalid = 1'b0, s_axis_tready, s_axis_tlast = 1'b0;
    logic [63:0] s_axis_tdata = '0;
    logic [7:0]  s_axis_tstrb = '0;
    logic        mem_wr_req, mem_wr_ack, mem_wr_valid, mem_wr_ready;
    logic [31:0] mem_wr_addr;
    logic [4:0]  mem_wr_len;
    logic [63:0] mem_wr_data;
    logic [7:0]  mem_wr_strb;
    logic        st_tvalid, st_tready = 1'b1, st_tlast;
    logic [63:0] st_tdata;
    logic [7:0]  st_tstrb;
    logic        busy, frame_done;
    logic [11:0] line_index;

    always #5 sysclk = ~sysclk;

    dmawr_line_writer dut (
        .sysclk(sysclk), .sysrst(sysrst), .cfg_enable(cfg_enable),
        .cfg_start_addr(cfg_start_addr), .cfg_line_pitch(cfg_line_pitch),
        .cfg_lines_per_frame(cfg_lines_per_frame),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tstrb(s_axis_tstrb), .s_axis_tlast(s_axis_tlast),
        .mem_wr_req(mem_wr_req), .mem_wr_ack(mem_wr_ack), .mem_wr_addr(mem_wr_addr),
        .mem_wr_len(mem_wr_len), .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready),
        .mem_wr_data(mem_wr_data), .mem_wr_strb(mem_wr_strb),
        .m_axis_status_tvalid(st_tvalid), .m_axis_status_tready(st_tready),
        .m_axis_status_tdata(st_tdata), .m_axis_status_tstrb(st_tstrb),
        .m_axis_status_tlast(st_tlast),
        .busy(busy), .frame_done(frame_done), .line_index(line_index)
    );

    int total = 0;
    int bad = 0;

    // Reference model state: pixel scoreboard, expected burst list, occupancy.
    logic [72:0] exp_q[$];
    logic [36:0] exp_burst_q[$];
    logic [31:0] obs_addr_q[$];
    int          occ = 0, beats_rem = 0, lines_done = 0, frames = 0, pushes = 0, pops = 0;
    logic        closed_pending = 1'b0, saw_full = 1'b0;
    logic [31:0] cur_addr = '0;
    logic [7:0]  last_in_strb = '0, last_out_strb = '0;
    int          ready_mode = 0, ack_mode = 0;
    logic        abort_tx = 1'b0, gaps = 1'b0;

    // Memory-side responder.
    initial begin
        mem_wr_ready = 1'b0;
        mem_wr_ack   = 1'b0;
        forever begin
            @(posedge sysclk); #1;
            case (ready_mode)
                0:       mem_wr_ready = 1'b1;
                1:       mem_wr_ready = ~mem_wr_ready;
                default: mem_wr_ready = 1'($urandom_range(0, 1));
            endcase
            mem_wr_ack = (ack_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    // Monitor: samples on the falling edge what the next rising edge will commit.
    initial begin
        logic [72:0] ent;
        logic [36:0] eb;
        forever begin
            @(negedge sysclk);
            if (sysrst) begin
                exp_q.delete();
                occ = 0; beats_rem = 0; closed_pending = 1'b0;
                lines_done = 0; frames = 0; pushes = 0; pops = 0;
            end else begin
                if (busy) begin
                    total++;
                    if (s_axis_tready !== (!closed_pending && occ < FifoDepth)) begin
                        bad++;
                        $display("FAIL tready got=%b occ=%0d closed=%b", s_axis_tready, occ,
                                 closed_pending);
                    end
                end
                if (s_axis_tvalid && !s_axis_tready && occ == FifoDepth) saw_full = 1'b1;
                if (s_axis_tvalid && s_axis_tready) begin
                    exp_q.push_back({s_axis_tlast, s_axis_tstrb, s_axis_tdata});
                    occ++; pushes++;
                    if (s_axis_tlast) begin
                        closed_pending = 1'b1;
                        last_in_strb = s_axis_tstrb;
                    end
                end
                if (mem_wr_req && mem_wr_ack) begin
                    total++;
                    if (beats_rem != 0) begin
                        bad++;
                        $display("FAIL short_burst remaining=%0d required=0", beats_rem);
                    end
                    total++;
                    if (exp_burst_q.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_burst addr=%h len=%0d", mem_wr_addr, mem_wr_len);
                    end else begin
                        eb = exp_burst_q.pop_front();
                        if ({mem_wr_addr, mem_wr_len} !== eb) begin
                            bad++;
                            $display("FAIL burst got addr=%h len=%0d exp addr=%h len=%0d",
                                     mem_wr_addr, mem_wr_len, eb[36:5], eb[4:0]);
                        end
                    end
                    beats_rem = int'(mem_wr_len);
                    cur_addr  = mem_wr_addr;
                end
                if (mem_wr_valid && mem_wr_ready) begin
                    total++;
                    if (exp_q.size() == 0 || beats_rem == 0) begin
                        bad++;
                        $display("FAIL extra_beat data=%h queued=%0d", mem_wr_data, exp_q.size());
                    end else begin
                        ent = exp_q.pop_front();
                        if ({mem_wr_strb, mem_wr_data} !== ent[71:0]) begin
                            bad++;
                            $display("FAIL beat got=%h/%h exp=%h/%h", mem_wr_strb, mem_wr_data,
                                     ent[71:64], ent[63:0]);
                        end
                        obs_addr_q.push_back(cur_addr);
                        cur_addr = cur_addr + 32'd8;
                        beats_rem--; occ--; pops++;
                        if (ent[72]) begin
                            closed_pending = 1'b0;
                            lines_done++;
                            last_out_strb = mem_wr_strb;
                        end
                    end
                end
                if (frame_done) frames++;
`ifndef DMAWR_STATUS_STREAM_EN
                total++;
                if ({st_tvalid, st_tdata, st_tstrb, st_tlast} !== 74'd0) begin
                    bad++;
                    $display("FAIL status_tied got=%b/%h required=0", st_tvalid, st_tdata);
                end
`endif
            end
        end
    end

    // Model of the burst split: full MAX_BURST bursts, then the remainder.
    task automatic expect_line(input logic [31:0] addr, input int n);
        for (int k = 0; k * 16 < n; k++) begin
            int len = (n - k * 16 > 16) ? 16 : n - k * 16;
            exp_burst_q.push_back({addr + 32'(128 * k), 5'(len)});
        end
    endtask

    task automatic send_line(input int n);
        int   sent = 0;
        int   guard = 0;
        logic hs;
        while (sent < n && !abort_tx && guard < 5000) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                s_axis_tvalid = 1'b0;
                @(posedge sysclk); #1;
                guard++;
            end else begin
                s_axis_tvalid = 1'b1;
                s_axis_tdata  = {$urandom(), $urandom()};
                s_axis_tstrb  = 8'($urandom());
                s_axis_tlast  = (sent == n - 1);
                do begin
                    @(negedge sysclk);
                    hs = s_axis_tvalid && s_axis_tready && !sysrst;
                    @(posedge sysclk); #1;
                    guard++;
                end while (!hs && !abort_tx && guard < 5000);
                if (hs) sent++;
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        total++;
        if (guard >= 5000) begin
            bad++;
            $display("FAIL send_timeout sent=%0d of %0d", sent, n);
        end
    endtask

    task automatic wait_lines(input int k);
        int g = 0;
        while (lines_done < k && g < 5000) begin
            @(posedge sysclk); #1;
            g++;
        end
        total++;
        if (lines_done < k) begin
            bad++;
            $display("FAIL line_timeout lines=%0d required=%0d", lines_done, k);
        end
        repeat (3) @(posedge sysclk);
        #1;
    endtask

    task automatic do_reset(input logic [31:0] start, input logic [15:0] pitch,
                            input logic [11:0] lpf);
        sysrst = 1'b1; cfg_enable = 1'b0; s_axis_tvalid = 1'b0; abort_tx = 1'b0;
        exp_burst_q.delete(); obs_addr_q.delete();
        cfg_start_addr = start; cfg_line_pitch = pitch; cfg_lines_per_frame = lpf;
        repeat (2) @(posedge sysclk);
        #1;
        sysrst = 1'b0;
        cfg_enable = 1'b1;
    endtask

    task automatic test_reset;
        sysrst = 1'b1; cfg_enable = 1'b1; s_axis_tvalid = 1'b1;
        repeat (2) @(posedge sysclk);
        #1;
        total += 6;
        if (s_axis_tready !== 1'b0) begin bad++; $display("FAIL rst_tready got=%b", s_axis_tready); end
        if ({mem_wr_req, mem_wr_valid} !== 2'b00) begin
            bad++; $display("FAIL rst_mem got=%b required=00", {mem_wr_req, mem_wr_valid});
        end
        if ({busy, frame_done} !== 2'b00) begin
            bad++; $display("FAIL rst_busy got=%b required=00", {busy, frame_done});
        end
        if (line_index !== 12'd0) begin bad++; $display("FAIL rst_index got=%0d", line_index); end
        if ({mem_wr_addr, mem_wr_len} !== 37'd0) begin
            bad++; $display("FAIL rst_addr got=%h/%0d required=0", mem_wr_addr, mem_wr_len);
        end
        if ({st_tvalid, st_tdata} !== 65'd0) begin
            bad++; $display("FAIL rst_status got=%b/%h required=0", st_tvalid, st_tdata);
        end
        s_axis_tvalid = 1'b0;
        sysrst = 1'b0;
        @(posedge sysclk); #1;
        total++;
        if ({busy, s_axis_tready} !== 2'b11) begin
            bad++; $display("FAIL rst_exit got=%b required=11", {busy, s_axis_tready});
        end
    endtask

    task automatic test_long_line;
        ready_mode = 0; ack_mode = 0; gaps = 1'b0;
        do_reset(32'h1000, 16'h100, 12'd4);
        expect_line(32'h1000, 48);
        send_line(48);
        wait_lines(1);
        total += 2;
        if (exp_burst_q.size() != 0) begin
            bad++; $display("FAIL long_bursts missing=%0d required=0", exp_burst_q.size());
        end
        if (line_index !== 12'd1) begin bad++; $display("FAIL long_index got=%0d required=1", line_index); end
    endtask

    task automatic test_short_tail;
        ready_mode = 2; ack_mode = 1; gaps = 1'b1;
        do_reset(32'h1000, 16'h100, 12'd4);
        expect_line(32'h1000, 20);
        send_line(20);
        wait_lines(1);
        total += 2;
        if (exp_burst_q.size() != 0) begin
            bad++; $display("FAIL tail_bursts missing=%0d required=0", exp_burst_q.size());
        end
        if (last_out_strb !== last_in_strb) begin
            bad++; $display("FAIL tail_strb got=%h required=%h", last_out_strb, last_in_strb);
        end
    endtask

    task automatic test_frame;
        ready_mode = 2; ack_mode = 1; gaps = 1'b1;
        do_reset(32'h1000, 16'h400, 12'd2);
        for (int i = 0; i < 4; i++) expect_line((i % 2 == 0) ? 32'h1000 : 32'h1400, 8);
        for (int i = 0; i < 4; i++) send_line(8);
        wait_lines(4);
        total += 3;
        if (exp_burst_q.size() != 0) begin
            bad++; $display("FAIL frame_bursts missing=%0d required=0", exp_burst_q.size());
        end
        if (frames != 2) begin bad++; $display("FAIL frame_done_count got=%0d required=2", frames); end
        if (line_index !== 12'd0) begin bad++; $display("FAIL frame_index got=%0d required=0", line_index); end
    endtask

    task automatic test_fifo_full;
        ready_mode = 1; ack_mode = 1; gaps = 1'b0; saw_full = 1'b0;
        do_reset(32'h1000, 16'h800, 12'd4);
        expect_line(32'h1000, 200);
        expect_line(32'h1800, 20);
        send_line(200);
        send_line(20);
        wait_lines(2);
        total += 2;
        if (!saw_full) begin bad++; $display("FAIL fifo_full_seen got=0 required=1"); end
        if (exp_burst_q.size() != 0) begin
            bad++; $display("FAIL full_bursts missing=%0d required=0", exp_burst_q.size());
        end
    endtask

    task automatic test_wrap;
        logic [31:0] exp_a;
        ready_mode = 0; ack_mode = 0; gaps = 1'b0;
        do_reset(32'hFFFF_FFF0, 16'h100, 12'd4);
        expect_line(32'hFFFF_FFF0, 4);
        send_line(4);
        wait_lines(1);
        total++;
        if (obs_addr_q.size() != 4) begin
            bad++; $display("FAIL wrap_count got=%0d required=4", obs_addr_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                exp_a = 32'hFFFF_FFF0 + 32'(8 * i);
                total++;
                if (obs_addr_q[i] !== exp_a) begin
                    bad++; $display("FAIL wrap_addr%0d got=%h required=%h", i, obs_addr_q[i], exp_a);
                end
            end
        end
    endtask

    task automatic test_enable_drop;
        ready_mode = 2; ack_mode = 1; gaps = 1'b1;
        do_reset(32'h2000, 16'h100, 12'd4);
        expect_line(32'h2000, 24);
        fork
            send_line(24);
            begin
                int g = 0;
                while (pushes < 10 && g < 2000) begin @(posedge sysclk); #1; g++; end
                cfg_enable = 1'b0;
            end
        join
        wait_lines(1);
        total += 2;
        if ({busy, s_axis_tready} !== 2'b00) begin
            bad++; $display("FAIL drop_idle got=%b required=00", {busy, s_axis_tready});
        end
        if (line_index !== 12'd0) begin bad++; $display("FAIL drop_index got=%0d required=0", line_index); end
        expect_line(32'h2000, 8);
        cfg_enable = 1'b1;
        send_line(8);
        wait_lines(2);
        total += 2;
        if (exp_burst_q.size() != 0) begin
            bad++; $display("FAIL drop_bursts missing=%0d required=0", exp_burst_q.size());
        end
        if (line_index !== 12'd1) begin bad++; $display("FAIL drop_index2 got=%0d required=1", line_index); end
    endtask

    task automatic test_lpf_zero;
        ready_mode = 0; ack_mode = 1; gaps = 1'b0;
        do_reset(32'h3000, 16'h40, 12'd0);
        expect_line(32'h3000, 4);
        expect_line(32'h3000, 4);
        send_line(4);
        send_line(4);
        wait_lines(2);
        total += 2;
        if (frames != 2) begin bad++; $display("FAIL lpf0_frames got=%0d required=2", frames); end
        if (exp_burst_q.size() != 0) begin
            bad++; $display("FAIL lpf0_bursts missing=%0d required=0", exp_burst_q.size());
        end
    endtask

    task automatic test_reset_mid_burst;
        ready_mode = 0; ack_mode = 0; gaps = 1'b0;
        do_reset(32'h4000, 16'h100, 12'd4);
        expect_line(32'h4000, 40);
        fork
            send_line(40);
            begin
                int g = 0;
                while (pops < 5 && g < 2000) begin @(posedge sysclk); #1; g++; end
                sysrst = 1'b1; abort_tx = 1'b1; cfg_enable = 1'b0;
                repeat (2) @(posedge sysclk);
                #1;
                sysrst = 1'b0;
            end
        join
        abort_tx = 1'b0;
        exp_burst_q.delete();
        for (int i = 0; i < 20; i++) begin
            @(negedge sysclk);
            total++;
            if ({mem_wr_valid, mem_wr_req, busy} !== 3'b000) begin
                bad++;
                $display("FAIL abort_quiet cycle=%0d got=%b required=000", i,
                         {mem_wr_valid, mem_wr_req, busy});
            end
        end
        @(posedge sysclk); #1;
        expect_line(32'h4000, 4);
        cfg_enable = 1'b1;
        send_line(4);
        wait_lines(1);
        total++;
        if (exp_burst_q.size() != 0) begin
            bad++; $display("FAIL abort_recover missing=%0d required=0", exp_burst_q.size());
        end
    endtask

    task automatic test_status;
        ready_mode = 0; ack_mode = 0; gaps = 1'b0;
`ifdef DMAWR_STATUS_STREAM_EN
        st_tready = 1'b0;
        do_reset(32'h1000, 16'h100, 12'd4);
        expect_line(32'h1000, 48);
        send_line(48);
        begin
            int g = 0;
            while (!st_tvalid && g < 200) begin @(negedge sysclk); g++; end
            total++;
            if (!st_tvalid) begin bad++; $display("FAIL status_timeout got=0 required=1"); end
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge sysclk);
            total += 2;
            if ({st_tvalid, st_tdata} !== {1'b1, 64'h0000_0000_0030_0000}) begin
                bad++; $display("FAIL status_hold cycle=%0d got=%b/%h", i, st_tvalid, st_tdata);
            end
            if ({mem_wr_req, line_index} !== 13'd0) begin
                bad++; $display("FAIL status_stall cycle=%0d req=%b index=%0d", i, mem_wr_req, line_index);
            end
        end
        @(posedge sysclk); #1;
        st_tready = 1'b1;
        @(negedge sysclk);
        total++;
        if ({st_tvalid, st_tdata, st_tstrb, st_tlast} !== {1'b1, 64'h0000_0000_0030_0000, 8'hFF, 1'b1}) begin
            bad++; $display("FAIL status_beat got=%b/%h/%h/%b", st_tvalid, st_tdata, st_tstrb, st_tlast);
        end
        @(negedge sysclk);
        total++;
        if ({st_tvalid, line_index} !== {1'b0, 12'd1}) begin
            bad++; $display("FAIL status_after got=%b/%0d required=0/1", st_tvalid, line_index);
        end
`else
        st_tready = 1'b0;
        do_reset(32'h1000, 16'h100, 12'd4);
        expect_line(32'h1000, 8);
        send_line(8);
        wait_lines(1);
        total++;
        if ({busy, line_index} !== {1'b1, 12'd1}) begin
            bad++; $display("FAIL status_off got=%b/%0d required=1/1", busy, line_index);
        end
        st_tready = 1'b1;
`endif
    endtask

    initial begin
        test_reset();
        test_long_line();
        test_short_tail();
        test_frame();
        test_fifo_full();
        test_wrap();
        test_enable_drop();
        test_lpf_zero();
        test_reset_mid_burst();
        test_status();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmawr_line_writer.md
# dmawr_line_writer

Write-side stage of the DMA write path: accepts the 64-bit AXI-stream pixel line produced by the HiSPi receiver (`hispi_top` m_axis) and converts each line into length-bounded memory-write bursts. Each line is written to a pitch-strided address. The block buffers each line in an internal FIFO and tracks line and frame position. When enabled, it returns a one-beat per-line status on a stream back toward the receiver's s_axis.

## Interface
Parameters:
- DATA_WIDTH, 64, stream and memory data width (fixed 64; strobe is DATA_WIDTH/8).
- ADDR_WIDTH, 32, memory byte-address width.
- FIFO_DEPTH, 64, line buffer depth in beats, power of 2, ≥ MAX_BURST.
- MAX_BURST, 16, maximum beats per burst, power of 2, ≤ 16.

Ports:
- sysclk  in  1  single clock.
- sysrst  in  1  synchronous, active-high reset.
- cfg_enable  in  1  accept new lines when high.
- cfg_start_addr  in  ADDR_WIDTH  frame base byte address, 8-byte aligned.
- cfg_line_pitch  in  16  byte stride between line starts.
- cfg_lines_per_frame  in  12  lines per frame; 0 is treated as 1.
- s_axis_tvalid / s_axis_tready  in / out  1  pixel stream handshake.
- s_axis_tdata  in  64  pixel data.
- s_axis_tstrb  in  8  byte strobe, passed through to memory.
- s_axis_tlast  in  1  last beat of line.
- mem_wr_req / mem_wr_ack  out / in  1  burst request handshake.
- mem_wr_addr  out  ADDR_WIDTH  burst start byte address.
- mem_wr_len  out  5  burst length in beats, 1..MAX_BURST.
- mem_wr_valid / mem_wr_ready  out / in  1  data beat handshake.
- mem_wr_data  out  64  data beat.
- mem_wr_strb  out  8  byte enables.
- m_axis_status_tvalid / m_axis_status_tready  out / in  1  status beat handshake.
- m_axis_status_tdata  out  64  status word.
- m_axis_status_tstrb  out  8  status byte strobe.
- m_axis_status_tlast  out  1  status last flag.
- busy  out  1  state is not IDLE.
- frame_done  out  1  one-cycle pulse after the last line of a frame.
- line_index  out  12  current line in frame.

## Operation
- FIFO stores {tlast, tstrb, tdata}; first-word-fall-through.
- s_axis_tready = (state≠IDLE) & !fifo_full & !line_closed.
- line_closed sets when a tlast beat is accepted and clears on entry to LINE_END. Only one line is ever resident in the FIFO.
- States:
  - IDLE: line_addr ← cfg_start_addr, line_index ← 0. Go to COLLECT when cfg_enable=1.
  - COLLECT: go to REQ when fifo_count ≥ MAX_BURST, or when line_closed=1 and fifo_count > 0.
  - REQ: mem_wr_len = min(MAX_BURST, fifo_count), latched on entry. mem_wr_addr = burst_addr. Hold mem_wr_req until mem_wr_ack, then go to DATA.
  - DATA: mem_wr_valid = 1, streaming beats from the FIFO. Go to LINE_END when the burst completes and the popped beat had tlast; otherwise go to COLLECT.
  - LINE_END: line_addr += cfg_line_pitch; burst_addr ← new line_addr; line_index += 1.
    - On the last line (line_index = lines_per_frame−1): pulse frame_done, line_index ← 0, line_addr ← cfg_start_addr.
    - Next state is IDLE if cfg_enable=0, else COLLECT.
- burst_addr += 8 per beat popped. All address arithmetic wraps modulo 2^ADDR_WIDTH.
- Deasserting cfg_enable mid-line completes the current line, then returns to IDLE with line_index reset.

## Timing
- Reset: all outputs 0, FIFO empty, state IDLE, line_closed 0.
- REQ is entered the cycle after the COLLECT condition becomes true. mem_wr_req rises that same cycle.
- mem_wr_addr and mem_wr_len are stable while mem_wr_req=1.
- Data: one beat per cycle when mem_wr_ready=1. Exactly mem_wr_len beats per burst.
- The FIFO can accept s_axis beats while a burst is draining, as long as line_closed=0.
- sysrst mid-burst aborts immediately: FIFO is flushed and no further beats are issued.
- Simultaneous FIFO push and pop leaves fifo_count unchanged.

## Configuration
- DMAWR_STATUS_STREAM_EN defined: LINE_END waits for the status beat to be accepted before leaving. The status beat is:
  - m_axis_status_tvalid=1;
  - tdata[11:0]=line_index (pre-increment), tdata[27:16]=beats in line, other bits 0;
  - tstrb=8'hFF, tlast=1.
- DMAWR_STATUS_STREAM_EN undefined: status outputs are tied to 0 and LINE_END lasts one cycle.

## Test plan
- 48-beat line, MAX_BURST=16, start 0x1000, mem_wr_ready=1 → three bursts, len 16, at addresses 0x1000, 0x1080, 0x1100.
- 20-beat line → bursts of len 16 and len 4. mem_wr_strb of the last beat equals the s_axis_tstrb of the tlast beat.
- Pitch 0x400, lines_per_frame=2, four 8-beat lines → line starts at 0x1000, 0x1400, 0x1000, 0x1400. frame_done pulses twice.
- mem_wr_ready toggling 1/0 with s_axis bursting → s_axis_tready drops at FIFO full (64 beats) and no data is lost or reordered. The second line is held off until LINE_END.
- start 0xFFFF_FFF0, 4-beat line → beat addresses 0xFFFF_FFF0, 0xFFFF_FFF8, 0x0000_0000, 0x0000_0008.
- With DMAWR_STATUS_STREAM_EN defined and m_axis_status_tready held low for 10 cycles → no second line is accepted. After the status beat is accepted, tdata=0x0000_0000_0030_0000 for the first line of 48 beats.
